// File: rtl/branch_predictor_btb.sv
// ----------------------------------------------------------------------------
// branch_predictor_btb
//
// Direct-mapped branch target buffer with per-entry saturating counters for
// the 5-stage pipeline. IF looks up the fetch PC with zero latency and gets a
// predicted next PC. EX trains the table when a branch resolves and raises
// flush/redirect_pc on a misprediction. Two statistics counters track the
// resolved branches and the mispredictions.
//
// Ports
//   clk             in   1       clock, rising edge
//   rst_n           in   1       asynchronous active-low reset
//   if_pc           in   ADDR_W  fetch PC to look up
//   pred_hit        out  1       valid entry with matching tag
//   pred_taken      out  1       predicted taken
//   pred_target     out  ADDR_W  predicted next PC
//   ex_valid        in   1       branch resolving in EX this cycle
//   ex_pc           in   ADDR_W  PC of the resolving branch
//   ex_taken        in   1       actual outcome
//   ex_target       in   ADDR_W  actual taken target
//   ex_pred_taken   in   1       prediction carried with the branch
//   ex_pred_target  in   ADDR_W  predicted next PC carried with the branch
//   flush           out  1       misprediction, kill IF/ID and ID/EX
//   redirect_pc     out  ADDR_W  correct next PC
//   stats_clr       in   1       synchronous clear of both statistics counters
//   branch_cnt      out  CNT_W   resolved branches
//   mispred_cnt     out  CNT_W   mispredictions
// ----------------------------------------------------------------------------
module branch_predictor_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    // ------------------------------------------------------------------
    // IF lookup: reads registered table contents only, so a same-cycle
    // update of the same entry is not visible until after the edge.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[ADDR_W-1:IDX_W+2];

    assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = pred_hit && ctr_q[if_idx][CTR_W-1];
    assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + PC_STEP);

    // ------------------------------------------------------------------
    // EX resolve. A taken branch predicted taken can still mispredict if
    // the carried target differs (stale or aliased BTB entry).
    // ------------------------------------------------------------------
    assign flush = ex_valid &&
                   ((ex_pred_taken != ex_taken) ||
                    (ex_taken && (ex_pred_target != ex_target)));

    assign redirect_pc = ex_taken ? ex_target : (ex_pc + PC_STEP);

    // ------------------------------------------------------------------
    // EX training: only the entry indexed by ex_pc can change.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_hit;
    logic              upd_en;
    logic [TAG_W-1:0]  upd_tag_d;
    logic [ADDR_W-1:0] upd_target_d;
    logic [CTR_W-1:0]  upd_ctr_d;

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // A not-taken miss leaves the table alone; never allocate for it.
    assign upd_en = ex_valid && (ex_hit || ex_taken);

    always_comb begin
        upd_tag_d    = tag_q[ex_idx];
        upd_target_d = target_q[ex_idx];
        upd_ctr_d    = ctr_q[ex_idx];
        if (ex_hit) begin
            if (ex_taken) begin
                upd_target_d = ex_target;
                if (ctr_q[ex_idx] != CTR_MAX) begin
                    upd_ctr_d = ctr_q[ex_idx] + CTR_W'(1);
                end
            end else if (ctr_q[ex_idx] != '0) begin
                upd_ctr_d = ctr_q[ex_idx] - CTR_W'(1);
            end
        end else begin
            // Allocation overwrites whatever aliased into this slot.
            upd_tag_d    = ex_tag;
            upd_target_d = ex_target;
            upd_ctr_d    = CTR_WT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (upd_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= upd_tag_d;
            target_q[ex_idx] <= upd_target_d;
            ctr_q[ex_idx]    <= upd_ctr_d;
        end
    end

    // ------------------------------------------------------------------
    // Statistics. Clear has priority over counting in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (stats_clr) begin
            branch_cnt_d  = '0;
            mispred_cnt_d = '0;
        end else begin
            branch_cnt_d  = branch_cnt_q + CNT_W'(ex_valid);
            mispred_cnt_d = mispred_cnt_q + CNT_W'(flush);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor_btb
//
// Self-checking bench for branch_predictor_btb with default parameters.
// Expected values are queued when stimulus is driven and compared at the
// following falling edge. Directed scenarios use hand-derived constants; a
// random phase uses a small behavioural model of the table and counters.
// ----------------------------------------------------------------------------
module tb_branch_predictor_btb;

    localparam int F_HIT   = 0;
    localparam int F_TAKEN = 1;
    localparam int F_TGT   = 2;
    localparam int F_FLUSH = 3;
    localparam int F_REDIR = 4;
    localparam int F_BCNT  = 5;
    localparam int F_MCNT  = 6;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        stats_clr;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_predictor_btb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .stats_clr      (stats_clr),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          fld;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int fld);
        case (fld)
            F_HIT:   return 32'(pred_hit);
            F_TAKEN: return 32'(pred_taken);
            F_TGT:   return pred_target;
            F_FLUSH: return 32'(flush);
            F_REDIR: return redirect_pc;
            F_BCNT:  return branch_cnt;
            F_MCNT:  return mispred_cnt;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int fld, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.fld = fld;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.fld), e.val);
        end
    endtask

    // Compare queued expectations at the falling edge, then cross one
    // rising edge and return just after it.
    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_drive(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                            input logic ptk, input logic [31:0] ptg);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tg;
        ex_pred_taken  = ptk;
        ex_pred_target = ptg;
    endtask

    task automatic ex_idle();
        ex_valid       = 1'b0;
        ex_pc          = '0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    // Mid-cycle reset pulse, clear of any clock edge.
    task automatic reset_pulse();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model for the random phase ----------------
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_b, m_m;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_b = '0;
        m_m = '0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = {24'h0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'b00};
        if ($urandom_range(0, 9) == 0) p[31:28] = 4'hF;
        return p;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] ipc, epc, etg, eptg, e_tgt;
    logic        ev, et, ept, sc, e_hit, e_tk, e_fl;
    int          ii;

    initial begin
        rst_n     = 1'b1;
        if_pc     = 32'h40;
        stats_clr = 1'b0;
        ex_idle();
        #1 rst_n = 1'b0;
        #2;
        // Reset state, before any clock edge.
        expect_v("rst_hit",   F_HIT,   32'h0);
        expect_v("rst_taken", F_TAKEN, 32'h0);
        expect_v("rst_tgt",   F_TGT,   32'h44);
        expect_v("rst_bcnt",  F_BCNT,  32'h0);
        expect_v("rst_mcnt",  F_MCNT,  32'h0);
        drain();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First taken resolve: mispredict, allocate.
        ex_drive(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        if_pc = 32'h40;
        expect_v("t2_prehit", F_HIT,   32'h0);
        expect_v("t2_pretgt", F_TGT,   32'h44);
        expect_v("t2_flush",  F_FLUSH, 32'h1);
        expect_v("t2_redir",  F_REDIR, 32'h80);
        expect_v("t2_bcnt0",  F_BCNT,  32'h0);
        step();
        ex_idle();
        expect_v("t2_hit",   F_HIT,   32'h1);
        expect_v("t2_taken", F_TAKEN, 32'h1);
        expect_v("t2_tgt",   F_TGT,   32'h80);
        expect_v("t2_bcnt",  F_BCNT,  32'h1);
        expect_v("t2_mcnt",  F_MCNT,  32'h1);
        step();

        // Saturate at 3, then decrement twice.
        for (int k = 0; k < 2; k++) begin
            ex_drive(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
            expect_v("t3_flush_ok", F_FLUSH, 32'h0);
            step();
        end
        ex_drive(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        expect_v("t3_flush_nt", F_FLUSH, 32'h1);
        expect_v("t3_redir_nt", F_REDIR, 32'h44);
        step();
        ex_idle();
        expect_v("t3_taken2", F_TAKEN, 32'h1);
        expect_v("t3_tgt2",   F_TGT,   32'h80);
        step();
        ex_drive(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        expect_v("t3_flush_nt2", F_FLUSH, 32'h1);
        step();
        ex_idle();
        expect_v("t3_hit1",   F_HIT,   32'h1);
        expect_v("t3_taken1", F_TAKEN, 32'h0);
        expect_v("t3_tgt1",   F_TGT,   32'h44);
        expect_v("t3_bcnt",   F_BCNT,  32'h5);
        expect_v("t3_mcnt",   F_MCNT,  32'h3);
        step();

        // Aliasing: 0x440 shares index 0 with 0x40.
        ex_drive(32'h440, 1'b1, 32'h100, 1'b0, 32'h0);
        if_pc = 32'h440;
        expect_v("t4_prehit", F_HIT,   32'h0);
        expect_v("t4_flush",  F_FLUSH, 32'h1);
        step();
        ex_idle();
        if_pc = 32'h40;
        expect_v("t4_old_hit", F_HIT, 32'h0);
        expect_v("t4_old_tgt", F_TGT, 32'h44);
        step();
        if_pc = 32'h440;
        expect_v("t4_new_hit",   F_HIT,   32'h1);
        expect_v("t4_new_taken", F_TAKEN, 32'h1);
        expect_v("t4_new_tgt",   F_TGT,   32'h100);
        step();
        ex_drive(32'h440, 1'b0, 32'h100, 1'b1, 32'h100);
        expect_v("t4_redir_nt", F_REDIR, 32'h444);
        step();
        ex_idle();
        expect_v("t4_ctr_hit",   F_HIT,   32'h1);
        expect_v("t4_ctr_taken", F_TAKEN, 32'h0);
        expect_v("t4_ctr_tgt",   F_TGT,   32'h444);
        expect_v("t4_bcnt",      F_BCNT,  32'h7);
        expect_v("t4_mcnt",      F_MCNT,  32'h5);
        step();

        // Fall-through PC wraps.
        if_pc = 32'hFFFF_FFFC;
        expect_v("wrap_hit", F_HIT, 32'h0);
        expect_v("wrap_tgt", F_TGT, 32'h0);
        step();

        // Retrain 0x40, then asynchronous reset mid-cycle.
        ex_drive(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        if_pc = 32'h40;
        step();
        ex_idle();
        expect_v("t6_hit_pre", F_HIT,  32'h1);
        expect_v("t6_bcnt",    F_BCNT, 32'h8);
        expect_v("t6_mcnt",    F_MCNT, 32'h6);
        step();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        expect_v("t6_async_hit",  F_HIT,   32'h0);
        expect_v("t6_async_tgt",  F_TGT,   32'h44);
        expect_v("t6_async_bcnt", F_BCNT,  32'h0);
        expect_v("t6_async_mcnt", F_MCNT,  32'h0);
        drain();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Same-edge lookup and update of an invalid entry: no bypass.
        ex_drive(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        expect_v("t5_same_hit", F_HIT,   32'h0);
        expect_v("t5_flush",    F_FLUSH, 32'h1);
        step();
        ex_drive(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        expect_v("t5_next_hit", F_HIT,   32'h1);
        expect_v("t5_next_tgt", F_TGT,   32'h80);
        expect_v("t5_ok_flush", F_FLUSH, 32'h0);
        expect_v("t5_bcnt1",    F_BCNT,  32'h1);
        expect_v("t5_mcnt1",    F_MCNT,  32'h1);
        step();
        ex_drive(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        stats_clr = 1'b1;
        expect_v("t5_ok_bcnt", F_BCNT, 32'h2);
        expect_v("t5_ok_mcnt", F_MCNT, 32'h1);
        step();
        stats_clr = 1'b0;
        ex_idle();
        expect_v("t5_clr_bcnt", F_BCNT, 32'h0);
        expect_v("t5_clr_mcnt", F_MCNT, 32'h0);
        step();

        // Random phase against the model.
        reset_pulse();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            ipc  = rand_pc();
            epc  = rand_pc();
            ev   = ($urandom_range(0, 3) != 0);
            et   = 1'($urandom_range(0, 1));
            ept  = 1'($urandom_range(0, 1));
            etg  = $urandom & 32'h0000_0FFC;
            eptg = ($urandom_range(0, 1) != 0) ? etg : ($urandom & 32'h0000_0FFC);
            sc   = ($urandom_range(0, 24) == 0);

            if_pc          = ipc;
            ex_valid       = ev;
            ex_pc          = epc;
            ex_taken       = et;
            ex_target      = etg;
            ex_pred_taken  = ept;
            ex_pred_target = eptg;
            stats_clr      = sc;

            ii    = int'(ipc[5:2]);
            e_hit = m_valid[ii] && (m_tag[ii] == ipc[31:6]);
            e_tk  = e_hit && (m_ctr[ii] >= 2);
            e_tgt = e_tk ? m_tgt[ii] : ipc + 32'd4;
            e_fl  = ev && ((ept != et) || (et && (eptg != etg)));

            expect_v("rnd_hit",   F_HIT,   32'(e_hit));
            expect_v("rnd_taken", F_TAKEN, 32'(e_tk));
            expect_v("rnd_tgt",   F_TGT,   e_tgt);
            expect_v("rnd_flush", F_FLUSH, 32'(e_fl));
            expect_v("rnd_redir", F_REDIR, et ? etg : epc + 32'd4);
            expect_v("rnd_bcnt",  F_BCNT,  m_b);
            expect_v("rnd_mcnt",  F_MCNT,  m_m);
            step();

            if (sc) begin
                m_b = '0;
                m_m = '0;
            end else begin
                m_b = m_b + 32'(ev);
                m_m = m_m + 32'(e_fl);
            end
            if (ev) begin
                ii = int'(epc[5:2]);
                if (m_valid[ii] && (m_tag[ii] == epc[31:6])) begin
                    if (et) begin
                        m_tgt[ii] = etg;
                        if (m_ctr[ii] < 3) m_ctr[ii]++;
                    end else if (m_ctr[ii] > 0) begin
                        m_ctr[ii]--;
                    end
                end else if (et) begin
                    m_valid[ii] = 1'b1;
                    m_tag[ii]   = epc[31:6];
                    m_tgt[ii]   = etg;
                    m_ctr[ii]   = 2;
                end
            end
        end
        stats_clr = 1'b0;
        ex_idle();

        chk("sb_left", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
